ov7670_capture: RTL
===================

# ov7670_capture

Captures the OV7670 parallel pixel bus (YUV422 mode) and produces the 8-bit luma stream that feeds the camera input of the output stream multiplexer (`tvalid_camera`/`tdata_camera`). It frames the sensor output with VSYNC/HREF, keeps only the Y bytes, drops a configurable number of settling frames after enable, and tags start-of-frame and end-of-line. It also counts pixels and lines and flags geometry errors. It runs entirely in the camera PCLK domain.

## Interface
Parameters:
- `H_ACTIVE`, 640: Y pixels per line (line carries 2*H_ACTIVE bytes).
- `V_ACTIVE`, 480: lines per frame.
- `SKIP_FRAMES`, 2: complete frames discarded after each enable, 0..15.
- `Y_FIRST`, 1: 1 means the Y byte is at even byte positions in a line (Y U Y V); 0 means odd positions (U Y V Y).

Ports:
- `aclk` in 1: camera PCLK; all logic on the rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `en` in 1: capture enable, level.
- `cam_vsync` in 1: high during vertical blanking.
- `cam_href` in 1: high while line bytes are valid.
- `cam_data` in 8: sensor byte bus.
- `tvalid` out 1: one-cycle pulse per Y pixel; drives `tvalid_camera`.
- `tdata` out 8: Y value; drives `tdata_camera`.
- `tuser` out 1: qualifies the first pixel of a frame.
- `tlast` out 1: qualifies the last pixel of a line (pixel H_ACTIVE-1).
- `frame_done` out 1: one-cycle pulse at the end of each delivered frame.
- `geom_err` out 1: sticky error flag; cleared only by reset or by a 0->1 edge on `en`.

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_data` are registered once (r-stage). All decisions use the registered copies. The vsync falling edge is detected from the r-stage and its delayed copy.
- State machine:
  - IDLE: outputs quiet. If `en`=1, go to SYNC and load the skip counter with SKIP_FRAMES.
  - SYNC: wait for a vsync falling edge. If skip counter = 0, go to ACTIVE; otherwise decrement it and go to SKIP.
  - SKIP: wait for a vsync rising edge, then go back to SYNC.
  - ACTIVE: deliver pixels. On a vsync rising edge, pulse `frame_done` and check the line count. Then go to SYNC (skip counter stays 0) if `en`=1, or to IDLE if `en`=0.
- Deasserting `en` in ACTIVE lets the current frame finish. Deasserting it in SYNC or SKIP returns to IDLE immediately.
- Byte phase toggles on every r-stage byte with `href`=1 and resets to 0 when `href`=0.
- A byte is a Y byte when phase = (Y_FIRST ? 0 : 1).
- Column counter (10 bit): increments on each Y byte, resets when href falls.
- Line counter (9 bit): increments when href falls after at least one byte. Resets on vsync falling edge.
- Pixel emission in ACTIVE: a Y byte with column < H_ACTIVE produces one `tvalid` pulse.
  - `tuser`=1 when column=0 and line=0.
  - `tlast`=1 when column=H_ACTIVE-1.
- Pixels with column >= H_ACTIVE, or with line >= V_ACTIVE, are dropped and set `geom_err`.
- `geom_err` is also set when:
  - href falls with a byte count other than 2*H_ACTIVE;
  - vsync rises with a line count other than V_ACTIVE.
- In SKIP and SYNC no pixels are emitted and no errors are checked.

## Timing
- Reset values: `tvalid`, `tdata`, `tuser`, `tlast`, `frame_done`, `geom_err` are all 0. State = IDLE and all counters = 0.
- Latency: a Y byte on `cam_data` at edge N produces `tvalid`/`tdata` at edge N+2 (r-stage, then output register). `tuser`/`tlast` are aligned with their `tvalid`.
- `tvalid` is at most 1 every 2 cycles. `tdata`/`tuser`/`tlast` hold their value between pulses; `tuser` and `tlast` are meaningful only while `tvalid`=1.
- The consumer has no backpressure; every pulse is final.
- `frame_done` is asserted 2 cycles after vsync rises on the pins.
- Reset asserted mid-frame: all outputs go to 0 immediately (asynchronously). After release, nothing is emitted until a full vsync falling edge plus SKIP_FRAMES frames have passed.
- `en` and `cam_vsync` changing in the same cycle: the state transition uses `en` as sampled at the vsync edge.

## Test plan
- Enable with SKIP_FRAMES=2, H_ACTIVE=8, V_ACTIVE=4, bytes Y=0x10+col, chroma=0x80 -> frames 1-2 produce no `tvalid`. Frame 3 produces 32 pulses, `tdata` 0x10..0x17 per line, and `tuser` only on the first pulse. `tlast` fires on every 8th pulse. `frame_done` fires once, and `geom_err`=0.
- Y_FIRST=0 with the UYVY order -> only odd-position bytes are emitted. First `tvalid` appears 2 cycles after the first Y byte.
- A 9-pixel line (18 bytes) in a frame of 8-pixel lines -> the 9th pixel is dropped and `geom_err`=1. It stays set on the next good frame and clears when `en` goes 0 then 1.
- `en` dropped at line 2 of an ACTIVE frame -> lines 2-3 still delivered. `frame_done` pulses, the state returns to IDLE, and no pixels are emitted in the next frame.
- `aresetn` pulsed mid-line -> all outputs 0 on the same cycle. The first post-reset pixel appears only in the frame that follows SKIP_FRAMES skipped frames.
- A frame with 3 lines when V_ACTIVE=4 -> `frame_done` pulses and `geom_err`=1.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 YUV422 capture: frames the sensor bus, keeps luma bytes,
// skips settling frames and flags line/frame geometry errors.
module ov7670_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2,
  parameter int Y_FIRST     = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       en,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       tvalid,
  output logic [7:0] tdata,
  output logic       tuser,
  output logic       tlast,
  output logic       frame_done,
  output logic       geom_err
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    SKIP,
    ACTIVE
  } state_t;

  localparam logic [9:0]  H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  V_LIM  = 9'(V_ACTIVE);
  localparam logic [10:0] B_LEN  = 11'(2 * H_ACTIVE);
  localparam logic [3:0]  SKIP_N = 4'(SKIP_FRAMES);
  localparam logic        Y_PH   = (Y_FIRST == 0);

  state_t      state_q, state_d;
  logic        vs_r_q, vs_r_d, hr_r_q, hr_r_d;
  logic        vs_d_q, vs_d_d, hr_d_q, hr_d_d;
  logic [7:0]  dat_r_q, dat_r_d;
  logic        en_q, en_d;
  logic        phase_q, phase_d;
  logic [9:0]  col_q, col_d;
  logic [10:0] bcnt_q, bcnt_d;
  logic [8:0]  line_q, line_d;
  logic [3:0]  skip_q, skip_d;
  logic        tvalid_q, tvalid_d, tuser_q, tuser_d;
  logic        tlast_q, tlast_d, fdone_q, fdone_d;
  logic        err_q, err_d;
  logic [7:0]  tdata_q, tdata_d;

  logic vs_fall, vs_rise, hr_fall, y_byte, set_err;

  always_comb begin
    vs_r_d  = cam_vsync;
    hr_r_d  = cam_href;
    dat_r_d = cam_data;
    vs_d_d  = vs_r_q;
    hr_d_d  = hr_r_q;
    en_d    = en;

    vs_fall = vs_d_q & ~vs_r_q;
    vs_rise = vs_r_q & ~vs_d_q;
    hr_fall = hr_d_q & ~hr_r_q;
    y_byte  = hr_r_q & (phase_q == Y_PH);
    phase_d = hr_r_q & ~phase_q;

    col_d = col_q;
    if (!hr_r_q)
      col_d = '0;
    else if (y_byte && col_q != '1)
      col_d = col_q + 10'd1;

    bcnt_d = bcnt_q;
    if (!hr_r_q)
      bcnt_d = '0;
    else if (bcnt_q != '1)
      bcnt_d = bcnt_q + 11'd1;

    line_d = line_q;
    if (vs_fall)
      line_d = '0;
    else if (hr_fall && bcnt_q != '0 && line_q != '1)
      line_d = line_q + 9'd1;
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tvalid_d = 1'b0;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    fdone_d  = 1'b0;
    set_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SYNC;
          skip_d  = SKIP_N;
        end
      end
      SYNC: begin
        if (!en) begin
          state_d = IDLE;
        end else if (vs_fall) begin
          if (skip_q == '0) begin
            state_d = ACTIVE;
          end else begin
            skip_d  = skip_q - 4'd1;
            state_d = SKIP;
          end
        end
      end
      SKIP: begin
        if (!en)
          state_d = IDLE;
        else if (vs_rise)
          state_d = SYNC;
      end
      ACTIVE: begin
        if (y_byte) begin
          if (col_q < H_LIM && line_q < V_LIM) begin
            tvalid_d = 1'b1;
            tdata_d  = dat_r_q;
            tuser_d  = (col_q == '0) && (line_q == '0);
            tlast_d  = (col_q == H_LAST);
          end else begin
            set_err = 1'b1;
          end
        end
        if (hr_fall && bcnt_q != B_LEN)
          set_err = 1'b1;
        // en is only honoured at frame end so a started frame completes
        if (vs_rise) begin
          fdone_d = 1'b1;
          if (line_q != V_LIM)
            set_err = 1'b1;
          state_d = en ? SYNC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = ((en & ~en_q) ? 1'b0 : err_q) | set_err;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      vs_r_q   <= 1'b0;
      hr_r_q   <= 1'b0;
      vs_d_q   <= 1'b0;
      hr_d_q   <= 1'b0;
      dat_r_q  <= '0;
      en_q     <= 1'b0;
      phase_q  <= 1'b0;
      col_q    <= '0;
      bcnt_q   <= '0;
      line_q   <= '0;
      skip_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      fdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_r_q   <= vs_r_d;
      hr_r_q   <= hr_r_d;
      vs_d_q   <= vs_d_d;
      hr_d_q   <= hr_d_d;
      dat_r_q  <= dat_r_d;
      en_q     <= en_d;
      phase_q  <= phase_d;
      col_q    <= col_d;
      bcnt_q   <= bcnt_d;
      line_q   <= line_d;
      skip_q   <= skip_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      fdone_q  <= fdone_d;
      err_q    <= err_d;
    end
  end

  assign tvalid     = tvalid_q;
  assign tdata      = tdata_q;
  assign tuser      = tuser_q;
  assign tlast      = tlast_q;
  assign frame_done = fdone_q;
  assign geom_err   = err_q;

endmodule
